// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED chaser controller.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT_L = 2'd0,
        MODE_SHIFT_R = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [7:0] SEED_L     = 8'h01;
    localparam logic [7:0] SEED_R     = 8'h80;
    localparam logic [7:0] SEED_BLINK = 8'h00;
    localparam int         NUM_SPEEDS = 4;

    function automatic logic [7:0] mode_seed(input mode_e m);
        logic [7:0] s;
        s = SEED_L;
        unique case (m)
            MODE_SHIFT_L: s = SEED_L;
            MODE_SHIFT_R: s = SEED_R;
            MODE_BOUNCE:  s = SEED_L;
            MODE_BLINK:   s = SEED_BLINK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter,
// and a single-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 320000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            // Any agreeing sample restarts the stability window
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED chaser: step timebase, pattern sequencer and
// front-panel mode/speed/pause control.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int BASE_PERIOD     = 32000000,
    parameter int DEBOUNCE_CYCLES = 320000,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_speed,
    input  logic       btn_pause,
    output logic [7:0] leds,
    output logic       tick_out,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       running
);

    localparam logic [CNT_W-1:0] BASE_P = CNT_W'(BASE_PERIOD);
    localparam logic [1:0] SPD_MAX = 2'(NUM_SPEEDS - 1);

    logic mode_p;
    logic speed_p;
    logic pause_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_speed),
        .press (speed_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_pause),
        .press (pause_p)
    );

    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d, step_dir;
    logic [1:0]       speed_q, speed_d;
    logic             run_q, run_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period;
    logic [7:0]       leds_q, leds_d, step_leds;
    logic             term;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_SHIFT_L;
            dir_q   <= DIR_LEFT;
            speed_q <= 2'd0;
            run_q   <= 1'b1;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            leds_q  <= SEED_L;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            run_q   <= run_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
        end
    end

    always_comb begin
        period    = BASE_P >> speed_q;
        term      = run_q && (cnt_q == period - CNT_W'(1));
        step_leds = leds_q;
        step_dir  = dir_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        speed_d   = speed_q;
        run_d     = run_q ^ pause_p;
        tick_d    = 1'b0;
        cnt_d     = cnt_q;
        leds_d    = leds_q;

        unique case (mode_q)
            MODE_SHIFT_L: step_leds = {leds_q[6:0], leds_q[7]};
            MODE_SHIFT_R: step_leds = {leds_q[0], leds_q[7:1]};
            MODE_BOUNCE: begin
                if (dir_q == DIR_LEFT) begin
                    step_leds = leds_q << 1;
                    if (step_leds == SEED_R) step_dir = DIR_RIGHT;
                end else begin
                    step_leds = leds_q >> 1;
                    if (step_leds == SEED_L) step_dir = DIR_LEFT;
                end
            end
            MODE_BLINK: step_leds = ~leds_q;
        endcase

        // Button presses pre-empt a coincident terminal count
        if (mode_p || speed_p) begin
            cnt_d = '0;
            if (mode_p) begin
                mode_d = mode_e'(mode_q + 2'd1);
                leds_d = mode_seed(mode_d);
                dir_d  = DIR_LEFT;
            end
            if (speed_p) begin
                speed_d = (speed_q == SPD_MAX) ? 2'd0 : speed_q + 2'd1;
            end
        end else if (term) begin
            cnt_d  = '0;
            leds_d = step_leds;
            dir_d  = step_dir;
            tick_d = 1'b1;
        end else if (run_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign leds     = leds_q;
    assign tick_out = tick_q;
    assign mode     = mode_q;
    assign speed    = speed_q;
    assign running  = run_q;

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Controller for the board LED chaser and step timebase. It owns a programmable step-period counter and sequences the 8 LEDs through selectable patterns. Three front-panel buttons select the pattern, select the speed, and pause or run the sequence. It sits between the raw button pins and the LED pins, clocked by the 32 MHz board clock.

Parameters:
BASE_PERIOD, 32000000, step period in clk cycles at speed 0 (1 s at 32 MHz)
DEBOUNCE_CYCLES, 320000, stable-sample count required to accept a button level (10 ms)
CNT_W, 25, width of the step counter; must hold BASE_PERIOD-1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  reset, asynchronous, active-high
btn_mode  in  1  raw async button; press advances pattern mode
btn_speed  in  1  raw async button; press advances speed level
btn_pause  in  1  raw async button; press toggles run/pause
leds  out  8  LED pattern
tick_out  out  1  one-cycle pulse coincident with each LED step
mode  out  2  current pattern mode
speed  out  2  current speed level
running  out  1  1 = stepping, 0 = paused

Behaviour:
- Reset (async assert, sync release): leds=0x01, mode=0, speed=0, running=1, tick_out=0, step counter=0, bounce direction=left, all debouncers cleared to "released".
- Button path: 2-flop synchroniser, then a debouncer. The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free gap restarts the count. A press pulse (1 cycle) is generated on the debounced 0->1 edge only; release makes no pulse.
- Step period P = BASE_PERIOD >> speed (speed 0..3 gives /1, /2, /4, /8).
- Step counter: while running, it increments each cycle. When counter == P-1: counter->0, LEDs step, and tick_out=1 on the same edge, so tick_out and the new leds value are visible in the same cycle. When paused, the counter and leds hold and tick_out=0.
- Modes, each with a seed value:
  - 0 SHIFT_L, seed 0x01: leds<<1; 0x80 wraps to 0x01.
  - 1 SHIFT_R, seed 0x80: leds>>1; 0x01 wraps to 0x80.
  - 2 BOUNCE, seed 0x01, dir=left: shift in dir. Reaching 0x80 sets dir=right; reaching 0x01 sets dir=left. The sequence is 01,02,...,80,40,...,01,02 with no repeated end value.
  - 3 BLINK, seed 0x00: alternates 0xFF / 0x00.
- Mode press: mode = mode+1 mod 4 (3 wraps to 0). leds load the new mode's seed, dir=left, counter=0, no tick. This applies while paused too.
- Speed press: speed = speed+1 mod 4, counter=0, leds unchanged, no tick.
- Pause press: running toggles. Counter is not cleared, so resume continues the partial period.
- Simultaneous press pulses in one cycle: all take effect. Mode and speed updates both apply, and the counter clears once. Pause toggles regardless. A terminal count in the same cycle as a mode or speed press is discarded: no tick, and the seed or current leds win.
- Reset mid-operation returns every output to its reset value immediately, independent of clk.

Decomposition:
- Package led_seq_pkg holds:
  - mode encodings MODE_SHIFT_L/MODE_SHIFT_R/MODE_BOUNCE/MODE_BLINK
  - seed constants SEED_L=0x01, SEED_R=0x80, SEED_BLINK=0x00
  - NUM_SPEEDS=4
- Sub-module btn_debounce (synchroniser + debounce counter + press-pulse edge detect, parameter DEBOUNCE_CYCLES) is instantiated three times.
- Top holds the step counter, pattern FSM, and mode/speed/run registers.

Test Plan:
(bench uses BASE_PERIOD=16, DEBOUNCE_CYCLES=4)
1. Reset release, no buttons -> tick_out pulses every 16 cycles. leds go 01,02,...,80,01. No tick occurs before cycle 16.
2. btn_mode held 10 cycles -> exactly one mode advance: mode=1, leds=0x80. Steps go 40,20,...,01,80. A 3-cycle glitch on btn_mode causes no change.
3. Press mode twice more (mode 2, then 3) and press again -> mode 3 shows FF,00,FF. The next press wraps to mode 0 with leds=0x01. Checking mode 2 confirms bounce 01..80..01 with no doubled 0x80.
4. Press speed 3 times -> tick period becomes 8, 4, 2 cycles in turn. The 4th press returns to 16. Each press clears the counter, so the first tick comes P cycles after the press pulse.
5. Pause press at counter=9 -> leds and tick_out frozen for 50 cycles. A resume press makes the next tick arrive 6 cycles after running=1.
6. Mode and speed pulses in the same cycle as a terminal count -> no tick, mode+1, speed+1, leds=new seed. Async reset asserted mid-period forces leds=0x01, mode=0, speed=0, running=1 before the next clk edge.
